// File: rtl/nfca_pkg.sv
// Shared definitions for the NFC-A transmit arbiter: FSM state encoding and
// guard counter width.
package nfca_pkg;

  localparam int GUARD_W = 16;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_XFER  = 2'd1;
  localparam state_t ST_GUARD = 2'd2;

endpackage

// File: rtl/nfca_tx_arbiter.sv
// Two-requester frame arbiter in front of the NFC-A TX controller: round-robin
// grant per frame, pass-through while a frame is in flight, then a guard gap.
module nfca_tx_arbiter
  import nfca_pkg::*;
#(
  parameter logic [GUARD_W-1:0] GUARD_CYCLES = 16'd1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s0_tvalid,
  output logic       s0_tready,
  input  logic [7:0] s0_tdata,
  input  logic [3:0] s0_tdatab,
  input  logic       s0_tlast,
  input  logic       s1_tvalid,
  output logic       s1_tready,
  input  logic [7:0] s1_tdata,
  input  logic [3:0] s1_tdatab,
  input  logic       s1_tlast,
  output logic       m_tvalid,
  input  logic       m_tready,
  output logic [7:0] m_tdata,
  output logic [3:0] m_tdatab,
  output logic       m_tlast,
  output logic [1:0] grant,
  output logic       busy
);

  // Handshake: a byte moves on a rising edge where tvalid & tready are both 1;
  // tvalid never waits on tready, and the granted side sees m_tready directly.

  state_t             state_q;
  logic [1:0]         grant_q;
  logic [GUARD_W-1:0] cnt_q;
  logic               last_s1_q;   // 1 when s1 owned the most recent grant

  logic xfer;
  logic pick_s1;
  logic hs_last;

  always_comb begin
    xfer     = (state_q == ST_XFER);
    m_tvalid = 1'b0;
    m_tdata  = 8'd0;
    m_tdatab = 4'd0;
    m_tlast  = 1'b0;
    if (xfer) begin
      if (grant_q[1]) begin
        m_tvalid = s1_tvalid;
        m_tdata  = s1_tdata;
        m_tlast  = s1_tlast;
        m_tdatab = s1_tvalid ? s1_tdatab : 4'd0;
      end else begin
        m_tvalid = s0_tvalid;
        m_tdata  = s0_tdata;
        m_tlast  = s0_tlast;
        m_tdatab = s0_tvalid ? s0_tdatab : 4'd0;
      end
    end
  end

  // grant_q is only non-zero in XFER, so it alone gates the ready paths.
  assign s0_tready = grant_q[0] & m_tready;
  assign s1_tready = grant_q[1] & m_tready;
  assign grant     = grant_q;
  assign busy      = (state_q != ST_IDLE);

  assign pick_s1 = s1_tvalid & (~s0_tvalid | ~last_s1_q);
  assign hs_last = m_tvalid & m_tready & m_tlast;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      grant_q   <= 2'b00;
      cnt_q     <= '0;
      last_s1_q <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (s0_tvalid | s1_tvalid) begin
            grant_q   <= pick_s1 ? 2'b10 : 2'b01;
            last_s1_q <= pick_s1;
            state_q   <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (hs_last) begin
            grant_q <= 2'b00;
            if (GUARD_CYCLES == '0) begin
              state_q <= ST_IDLE;
            end else begin
              cnt_q   <= GUARD_CYCLES - 16'd1;
              state_q <= ST_GUARD;
            end
          end
        end
        ST_GUARD: begin
          // The cycle that reads zero is the last guard cycle.
          if (cnt_q == '0) state_q <= ST_IDLE;
          else             cnt_q   <= cnt_q - 16'd1;
        end
        default: begin
          state_q <= ST_IDLE;
          grant_q <= 2'b00;
        end
      endcase
    end
  end

endmodule
